// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: data-bus access signals shared by the core and the UART window
interface uart_tx_mmio_if;
  logic        en;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output en, wr, addr, wdata, input rdata);
  modport slave  (input en, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor
module uart_tx_mmio #(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           txd,
  output logic           irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   div_q, div_d, tmr_q, tmr_d, reload;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic          txd_q, txd_d, ovf_q, ovf_d, te_q, te_d, ie_q, ie_d;
  logic [31:0]   rdata_q, rdata_d, status;
  logic [1:0]    sel;
  logic          hit, full, empty, wr_tx, wr_div, wr_ctrl, push, pop;
  always_comb begin
    sel     = bus.addr[3:2];
    hit     = bus.en && (bus.addr[31:4] == BASE[31:4]);
    full    = cnt_q == CW'(FIFO_DEPTH);
    empty   = cnt_q == '0;
    wr_tx   = hit && bus.wr && sel == 2'd0;
    wr_div  = hit && bus.wr && sel == 2'd2;
    wr_ctrl = hit && bus.wr && sel == 2'd3;
    pop     = state_q == IDLE && te_q && !empty;
    // a pop in the same edge frees a slot, so a full FIFO still accepts the push
    push    = wr_tx && (!full || pop);
    reload  = (div_q == '0) ? 16'd0 : div_q - 16'd1;
    status  = {20'd0, 4'(cnt_q), 4'd0, ovf_q, empty, full, state_q != IDLE};
    wp_d    = push ? wp_q + PW'(1) : wp_q;
    rp_d    = pop ? rp_q + PW'(1) : rp_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    ovf_d   = (wr_tx && full && !pop) ? 1'b1 : (wr_ctrl && bus.wdata[2]) ? 1'b0 : ovf_q;
    div_d   = wr_div ? bus.wdata[15:0] : div_q;
    te_d    = wr_ctrl ? bus.wdata[0] : te_q;
    ie_d    = wr_ctrl ? bus.wdata[1] : ie_q;
    rdata_d = !(hit && !bus.wr) ? rdata_q :
              sel == 2'd0 ? 32'd0 :
              sel == 2'd1 ? status :
              sel == 2'd2 ? {16'd0, div_q} : {30'd0, ie_q, te_q};
    state_d = state_q;
    tmr_d   = (tmr_q == '0) ? tmr_q : tmr_q - 16'd1;
    sh_d    = sh_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE:  if (pop) begin
        state_d = START;
        sh_d    = mem_q[rp_q];
        txd_d   = 1'b0;
        tmr_d   = reload;
      end
      START: if (tmr_q == '0) begin
        state_d = DATA;
        bit_d   = 3'd0;
        txd_d   = sh_q[0];
        tmr_d   = reload;
      end
      DATA:  if (tmr_q == '0) begin
        tmr_d   = reload;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
        txd_d   = (bit_q == 3'd7) ? 1'b1 : sh_q[1];
        sh_d    = sh_q >> 1;
        bit_d   = bit_q + 3'd1;
      end
      STOP:  if (tmr_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      div_q   <= DIV_RESET;
      tmr_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      te_q    <= 1'b0;
      ie_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tmr_q   <= tmr_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      te_q    <= te_d;
      ie_q    <= ie_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.wdata[7:0];
  end
  assign bus.rdata = rdata_q;
  assign txd       = txd_q;
  assign irq       = ie_q && empty;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench for the memory-mapped UART transmitter
module tb_uart_tx_mmio;
  localparam logic [31:0] B = 32'h0000_1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd, irq;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  uart_tx_mmio_if bus ();
  uart_tx_mmio dut (.clk(clk), .rst(rst), .bus(bus), .txd(txd), .irq(irq));
  always #5 clk = ~clk;
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.en = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.en = 1'b0; bus.wr = 1'b0;
  endtask
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus.en = 1'b1; bus.wr = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.en = 1'b0;
    d = bus.rdata;
  endtask
  task automatic trace(input int p_lo, input int p_hi, input int sw);
    logic [7:0] b;
    logic [9:0] f;
    int n;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: queue size=0 want >0");
      return;
    end
    b = exp_q.pop_front();
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      n = (i < sw) ? p_lo : p_hi;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        total++;
        if (txd !== f[i]) begin
          bad++;
          $display("FAIL frame %h bit%0d clk%0d: txd=%b want %b", b, i, k, txd, f[i]);
        end
      end
    end
    @(negedge clk);
    total++;
    if (txd !== 1'b1) begin
      bad++;
      $display("FAIL idle after %h: txd=%b want 1", b, txd);
    end
  endtask
  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset txd: %b want 1", txd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset irq: %b want 0", irq); end
    bus_rd(B + 4, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL reset status: %h want 00000004", d); end
    bus_rd(B + 8, d);
    total++; if (d !== 32'd16) begin bad++; $display("FAIL reset div: %0d want 16", d); end
    bus_wr(32'h0000_2008, 32'd5);
    bus_rd(B + 8, d);
    total++; if (d !== 32'd16) begin bad++; $display("FAIL nonhit write: div=%0d want 16", d); end
    bus_rd(B, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL txdata read: %h want 0", d); end
  endtask
  task automatic test_single();
    logic [7:0] b;
    logic [9:0] f;
    logic want_t, want_b;
    int idx;
    bus_wr(B + 8, 32'd4);
    bus_wr(B + 12, 32'd1);
    exp_q.push_back(8'h55);
    bus_wr(B, 32'h55);
    b = exp_q.pop_front();
    f = {1'b1, b, 1'b0};
    bus.en = 1'b1; bus.wr = 1'b0; bus.addr = B + 4;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      idx = (k - 1) / 4;
      want_t = (idx > 9) ? 1'b1 : f[idx];
      want_b = (k >= 2 && k <= 41);
      total++;
      if (txd !== want_t) begin bad++; $display("FAIL single txd clk%0d: %b want %b", k, txd, want_t); end
      total++;
      if (bus.rdata[0] !== want_b) begin bad++; $display("FAIL single busy clk%0d: %b want %b", k, bus.rdata[0], want_b); end
    end
    bus.en = 1'b0;
  endtask
  task automatic test_overflow();
    logic [31:0] d;
    bus_wr(B + 12, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h41 + i));
      bus_wr(B, 32'(8'h41 + i));
    end
    bus_rd(B + 4, d);
    total++; if (d !== 32'h40A) begin bad++; $display("FAIL ovf status: %h want 0000040a", d); end
    bus_wr(B + 12, 32'd1);
    repeat (4) trace(4, 4, 10);
    bus_rd(B + 4, d);
    total++; if (d !== 32'hC) begin bad++; $display("FAIL drained status: %h want 0000000c", d); end
    bus_wr(B + 12, 32'd5);
    bus_rd(B + 4, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL ovf clear: status=%h want 00000004", d); end
    bus_rd(B + 12, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ctrl read: %h want 00000001", d); end
  endtask
  task automatic test_div();
    bus_wr(B + 8, 32'd0);
    exp_q.push_back(8'h3C);
    bus_wr(B, 32'h3C);
    trace(1, 1, 10);
    bus_wr(B + 8, 32'd2);
    exp_q.push_back(8'hC5);
    bus_wr(B, 32'hC5);
    fork
      trace(2, 8, 5);
      begin
        repeat (9) @(negedge clk);
        bus_wr(B + 8, 32'd8);
      end
    join
  endtask
  task automatic test_back_to_back();
    logic want;
    bus_wr(B + 8, 32'd2);
    bus_wr(B + 12, 32'd3);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq idle: %b want 1", irq); end
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h0F);
    fork
      begin
        bus_wr(B, 32'hA0);
        bus_wr(B, 32'h0F);
      end
      begin
        @(negedge clk);
        trace(2, 2, 10);
        trace(2, 2, 10);
      end
      begin
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq after push: %b want 0", irq); end
        for (int k = 1; k <= 24; k++) begin
          @(negedge clk);
          want = (k >= 22);
          total++;
          if (irq !== want) begin bad++; $display("FAIL irq clk%0d: %b want %b", k, irq, want); end
        end
      end
    join
  endtask
  task automatic test_reset_mid();
    logic [31:0] d;
    int errs;
    bus_wr(B + 8, 32'd4);
    bus_wr(B + 12, 32'd1);
    bus_wr(B, 32'h11);
    bus_wr(B, 32'h22);
    bus_wr(B, 32'h33);
    repeat (11) @(negedge clk);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL mid bit2: txd=%b want 0", txd); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL mid reset txd: %b want 1", txd); end
    bus_rd(B + 4, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL mid reset status: %h want 00000004", d); end
    errs = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL post reset idle: low clocks=%0d want 0", errs); end
  endtask
  initial begin
    bus.en = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_single();
    test_overflow();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the vcore data bus, alongside data_mem. It decodes a 16-byte register window and buffers core writes in a small FIFO. It serialises the buffered bytes as 8N1 frames on `txd`, so test programs can emit characters during simulation and on hardware.

## Interface
- `BASE`, default 32'h0000_1000: window base address; bits [3:0] ignored.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, ≥2.
- `DIV_RESET`, default 16'd16: reset value of the baud divisor.
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: bus access strobe; same bus as data_mem.
- `wr`  in  1: 1 = write, 0 = read.
- `addr`  in  32: byte address.
- `wdata`  in  32: write data.
- `rdata`  out  32: registered read data.
- `txd`  out  1: serial output, idle high.
- `irq`  out  1: level, high while FIFO empty and CTRL.IE=1.

## Operation
- Hit is `en && addr[31:4]==BASE[31:4]`. Register select is `addr[3:2]`. Non-hit accesses are ignored.
- Register 0x0 TXDATA (W):
  - A write pushes `wdata[7:0]`.
  - If the FIFO is full, the byte is dropped and STATUS.OVF is set.
  - A read of 0x0 returns 0.
- Register 0x4 STATUS (R):
  - bit0 BUSY (FSM≠IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky).
  - bits[11:8] FIFO count. All other bits are 0.
  - Writes are ignored.
- Register 0x8 DIV (R/W): bits[15:0]. Bit period is `max(DIV,1)` clocks.
- Register 0xC CTRL (R/W):
  - bit0 TE (transmit enable), bit1 IE.
  - Writing 1 to bit2 clears OVF; bit2 reads as 0.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE → START when TE=1 and FIFO is non-empty: pop the FIFO, load the shift register, `txd`←0.
  - START → DATA after one bit period; `txd`←bit0.
  - DATA shifts LSB first and holds each bit one bit period. After bit7's period, go to STOP with `txd`←1.
  - STOP → IDLE after one bit period.
- Bit timer:
  - Loaded with `max(DIV,1)-1` on every state or bit change; counts down to 0.
  - The DIV value is sampled at each reload. A DIV write mid-frame therefore takes effect from the next bit.
- Clearing TE mid-frame: the current frame completes; no further pops occur.
- Simultaneous push and pop in the same cycle:
  - The count is unchanged.
  - When full, the push is accepted because the pop frees an entry in the same edge. OVF is not set.
- Pointers wrap modulo FIFO_DEPTH. Count width is `$clog2(FIFO_DEPTH)+1`.
- Simultaneous OVF set (overflowing push) and OVF clear (CTRL write) cannot occur, since there is one access per cycle.

## Timing
- Reset values:
  - `rdata`=0, `txd`=1, `irq`=0.
  - FSM in IDLE, FIFO empty, OVF=0, DIV=DIV_RESET, CTRL=0.
- Reset mid-frame: `txd` returns to 1 at the reset edge and the FIFO is flushed; the in-progress frame is not completed.
- Read latency: `rdata` updates on the edge where a read hit is sampled, so it is valid one cycle after `en`. `rdata` holds its value otherwise.
- Write effect: register and FIFO state change at the edge sampling the write.
- Frame start: with TE=1, FSM in IDLE and the FIFO empty, a TXDATA write at edge T causes `txd` to fall at edge T+1.
- A frame is exactly 10×max(DIV,1) clocks.
- Back-to-back bytes: the STOP→IDLE edge is followed by IDLE→START on the next edge. This gives exactly one idle-high clock between frames.
- STATUS reflects state before the sampling edge, i.e. it does not include a same-cycle push or pop.

## Test plan
- Reset check: assert `rst` for 3 cycles → `txd`=1, `irq`=0, STATUS read = 0x0000_0004, DIV read = 16.
- Single byte:
  - Stimulus: DIV=4, CTRL=1, write 0x55 to TXDATA.
  - Response: `txd` = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks (40 clocks total), starting 1 cycle after the write edge.
  - BUSY=1 throughout the frame, then 0.
- FIFO overflow:
  - Stimulus: TE=0, write 0x41..0x45 (5 bytes) with FIFO_DEPTH=4.
  - STATUS = FULL|OVF, count 4.
  - Then set TE=1 → exactly 0x41..0x44 are transmitted.
  - A CTRL write of 0x5 clears OVF.
- Divisor edge cases:
  - DIV=0 → 1-clock bits, frame of 10 clocks.
  - A DIV write of 8 during bit3 of a DIV=2 frame → bits 4..7 and STOP last 8 clocks each.
- Back-to-back and irq:
  - Stimulus: IE=1, write 0xA0, 0x0F.
  - Response: two frames separated by one idle clock.
  - `irq` drops after the first push and rises when the second byte is popped.
- Reset mid-frame: `rst` asserted during DATA bit2 with 2 bytes queued → next cycle `txd`=1, STATUS=0x4; no further frames.
